// File: rtl/bmp180_pkg.sv
// bmp180_pkg -- shared constants and types for the BMP180 register-level
// responder: register addresses, command codes, conversion-time table,
// calibration ROM contents and the FSM state encodings.
package bmp180_pkg;

  // Register map
  localparam logic [7:0] ADDR_CAL_FIRST  = 8'hAA;
  localparam logic [7:0] ADDR_CAL_LAST   = 8'hBF;
  localparam logic [7:0] ADDR_CHIP_ID    = 8'hD0;
  localparam logic [7:0] ADDR_SOFT_RESET = 8'hE0;
  localparam logic [7:0] ADDR_CTRL_MEAS  = 8'hF4;
  localparam logic [7:0] ADDR_OUT_MSB    = 8'hF6;
  localparam logic [7:0] ADDR_OUT_LSB    = 8'hF7;
  localparam logic [7:0] ADDR_OUT_XLSB   = 8'hF8;

  localparam logic [7:0] CHIP_ID         = 8'h55;
  localparam logic [7:0] SOFT_RESET_CODE = 8'hB6;

  // Command codes written to ctrl_meas. Pressure commands carry oss in [7:6].
  localparam logic [7:0] CMD_TEMP       = 8'h2E;
  localparam logic [5:0] CMD_PRESS_LOW6 = 6'h34;

  // Conversion times in microseconds
  localparam int CONV_US_W = 15;
  localparam logic [CONV_US_W-1:0] TEMP_CONV_US = 15'd4500;
  localparam logic [3:0][CONV_US_W-1:0] PRESS_CONV_US =
    {15'd25500, 15'd13500, 15'd7500, 15'd4500};   // index = oss

  // Down-counter width: 25500 us * 50 cycles/us still fits in 21 bits.
  localparam int CONV_CNT_W = 21;

  // Reset value of the result registers
  localparam logic [7:0] OUT_MSB_RESET = 8'h80;

  // Calibration ROM, 11 words MSB first: AC1..AC6, B1, B2, MB, MC, MD
  localparam logic [22*8-1:0] CAL_ROM = {
    16'h0198, 16'hFFB8, 16'hC7D1, 16'h7FE5, 16'h7FF5, 16'h5A71,
    16'h182E, 16'h0004, 16'h8000, 16'hDDF9, 16'h0B34
  };

  // Byte idx (0 = address 0xAA) of the calibration ROM
  function automatic logic [7:0] cal_rom_byte(input logic [4:0] idx);
    int unsigned pos;
    pos = 21 - int'(idx);
    return CAL_ROM[pos*8 +: 8];
  endfunction

  typedef enum logic {
    BUS_WAIT_PTR = 1'b0,
    BUS_DATA     = 1'b1
  } bus_state_t;

  typedef enum logic {
    CONV_IDLE = 1'b0,
    CONV_BUSY = 1'b1
  } conv_state_t;

endpackage

// File: rtl/bmp180_conv_timer.sv
// bmp180_conv_timer -- conversion FSM and down-counter for the responder.
// A start pulse loads conv_us*CYCLES_PER_US-1 and drops eoc on the same
// edge; eoc rises exactly conv_us*CYCLES_PER_US cycles later, on the edge
// at which done is high (done is combinational so the result registers
// load on that very edge). abort returns everything to reset values.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   start           accepted conversion start (ignored while busy)
//   conv_us         conversion time in microseconds, valid with start
//   abort           synchronous return to idle (soft reset)
//   eoc             1 when idle, 0 while converting (registered)
//   done            high in the last converting cycle
//   state           current conversion FSM state
module bmp180_conv_timer
  import bmp180_pkg::*;
#(
  parameter int CYCLES_PER_US = 50
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CONV_US_W-1:0] conv_us,
  input  logic                 abort,
  output logic                 eoc,
  output logic                 done,
  output conv_state_t          state
);

  localparam logic [CONV_CNT_W-1:0] CYC_PER_US = CONV_CNT_W'(CYCLES_PER_US);

  logic [CONV_CNT_W-1:0] cnt;

  assign done = (state == CONV_BUSY) && (cnt == '0) && !abort;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= CONV_IDLE;
      cnt   <= '0;
      eoc   <= 1'b1;
    end else if (abort) begin
      state <= CONV_IDLE;
      cnt   <= '0;
      eoc   <= 1'b1;
    end else begin
      case (state)
        CONV_IDLE: begin
          if (start) begin
            state <= CONV_BUSY;
            cnt   <= CONV_CNT_W'(conv_us) * CYC_PER_US - CONV_CNT_W'(1);
            eoc   <= 1'b0;
          end
        end
        CONV_BUSY: begin
          if (cnt == '0) begin
            state <= CONV_IDLE;
            eoc   <= 1'b1;
          end else begin
            cnt <= cnt - CONV_CNT_W'(1);
          end
        end
        default: begin
          state <= CONV_IDLE;
          eoc   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/bmp180_responder.sv
// bmp180_responder -- register-level BMP180 emulation behind a byte-level
// I2C slave. First byte after bus_start loads the register pointer; later
// written bytes go to reg[ptr] (only ctrl_meas, and 0xE0 when the soft
// reset option is built in, are writable); every byte moved in either
// direction advances the pointer. datasend is a registered copy of
// reg[ptr], so it settles two cycles after any pointer/register change.
//
// Handshake: bus_start, received and sended are single-cycle pulses from
// the slave; received carries datareceive. bus_start has priority over
// both, and received has priority over sended in the same cycle.
//
// Build option: define BMP180_SOFT_RESET_EN to make 0xE0 writable; writing
// 0xB6 there restores ctrl_meas, the result registers and the conversion
// FSM to their reset values (ptr and the bus FSM are untouched).
//
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   bus_start      START / repeated START addressed to this device
//   datareceive    byte written by the master, valid with received
//   received       datareceive valid pulse
//   datasend       byte returned on the next master read
//   sended         datasend was shifted out pulse
//   temp_raw       raw temperature sampled when a temperature result loads
//   press_raw      raw pressure sampled when a pressure result loads
//   eoc            end-of-conversion, low while converting
module bmp180_responder
  import bmp180_pkg::*;
#(
  parameter int CYCLES_PER_US = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_start,
  input  logic [7:0]  datareceive,
  input  logic        received,
  output logic [7:0]  datasend,
  input  logic        sended,
  input  logic [15:0] temp_raw,
  input  logic [18:0] press_raw,
  output logic        eoc
);

  bus_state_t  bus_state;
  conv_state_t conv_state;

  logic [7:0] ptr;
  logic [7:0] ctrl_meas;
  logic [7:0] out_msb;
  logic [7:0] out_lsb;
  logic [7:0] out_xlsb;

  logic                 conv_done;
  logic                 soft_rst;
  logic                 reg_wr;
  logic                 ctrl_wr;
  logic                 is_temp_cmd;
  logic                 is_press_cmd;
  logic                 conv_start;
  logic [CONV_US_W-1:0] conv_us;
  logic [23:0]          press_word;
  logic [7:0]           rd_byte;

  // A data-phase write; the pointer-load byte is not a register write.
  assign reg_wr  = received && !bus_start && (bus_state == BUS_DATA);
  // ctrl_meas is frozen while a conversion runs.
  assign ctrl_wr = reg_wr && (ptr == ADDR_CTRL_MEAS) && eoc;

  assign is_temp_cmd  = (datareceive == CMD_TEMP);
  assign is_press_cmd = (datareceive[5:0] == CMD_PRESS_LOW6);
  assign conv_start   = ctrl_wr && (is_temp_cmd || is_press_cmd);
  assign conv_us      = is_temp_cmd ? TEMP_CONV_US : PRESS_CONV_US[datareceive[7:6]];

`ifdef BMP180_SOFT_RESET_EN
  assign soft_rst = reg_wr && (ptr == ADDR_SOFT_RESET) && (datareceive == SOFT_RESET_CODE);
`else
  assign soft_rst = 1'b0;
`endif

  // Pressure result: UP left-justified by (8 - oss), upper bits dropped.
  assign press_word = {5'b0, press_raw} << (4'd8 - {2'b00, ctrl_meas[7:6]});

  bmp180_conv_timer #(
    .CYCLES_PER_US(CYCLES_PER_US)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .start  (conv_start),
    .conv_us(conv_us),
    .abort  (soft_rst),
    .eoc    (eoc),
    .done   (conv_done),
    .state  (conv_state)
  );

  // Bus FSM and register pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_state <= BUS_WAIT_PTR;
      ptr       <= 8'h00;
    end else if (bus_start) begin
      bus_state <= BUS_WAIT_PTR;
    end else if (received) begin
      if (bus_state == BUS_WAIT_PTR) begin
        ptr       <= datareceive;
        bus_state <= BUS_DATA;
      end else begin
        ptr <= ptr + 8'd1;
      end
    end else if (sended) begin
      ptr <= ptr + 8'd1;
    end
  end

  // ctrl_meas and result registers. ctrl_meas cannot change mid-conversion,
  // so at done it still holds the command that started the conversion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_meas <= 8'h00;
      out_msb   <= OUT_MSB_RESET;
      out_lsb   <= 8'h00;
      out_xlsb  <= 8'h00;
    end else if (soft_rst) begin
      ctrl_meas <= 8'h00;
      out_msb   <= OUT_MSB_RESET;
      out_lsb   <= 8'h00;
      out_xlsb  <= 8'h00;
    end else begin
      if (ctrl_wr) begin
        ctrl_meas <= datareceive;
      end
      if (conv_done) begin
        if (ctrl_meas == CMD_TEMP) begin
          out_msb  <= temp_raw[15:8];
          out_lsb  <= temp_raw[7:0];
          out_xlsb <= 8'h00;
        end else begin
          out_msb  <= press_word[23:16];
          out_lsb  <= press_word[15:8];
          out_xlsb <= press_word[7:0];
        end
      end
    end
  end

  // Read map; sco (bit 5 of ctrl_meas) reflects the live conversion state.
  always_comb begin
    rd_byte = 8'h00;
    if (ptr >= ADDR_CAL_FIRST && ptr <= ADDR_CAL_LAST) begin
      rd_byte = cal_rom_byte(5'(ptr - ADDR_CAL_FIRST));
    end else begin
      case (ptr)
        ADDR_CHIP_ID:   rd_byte = CHIP_ID;
        ADDR_CTRL_MEAS: rd_byte = {ctrl_meas[7:6], (conv_state == CONV_BUSY), ctrl_meas[4:0]};
        ADDR_OUT_MSB:   rd_byte = out_msb;
        ADDR_OUT_LSB:   rd_byte = out_lsb;
        ADDR_OUT_XLSB:  rd_byte = out_xlsb;
        default:        rd_byte = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      datasend <= 8'h00;
    end else begin
      datasend <= rd_byte;
    end
  end

endmodule

// File: tb/tb_bmp180_responder.sv
// tb_bmp180_responder -- self-checking bench for bmp180_responder with
// CYCLES_PER_US=1. Register reads go through an expected-value queue;
// single-address reads come from a vector table, multi-cycle cases
// (conversions, soft reset, async reset) are hand-written sequences.
module tb_bmp180_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        bus_start = 1'b0;
  logic [7:0]  datareceive = 8'h00;
  logic        received = 1'b0;
  logic [7:0]  datasend;
  logic        sended = 1'b0;
  logic [15:0] temp_raw = 16'h0000;
  logic [18:0] press_raw = 19'h0;
  logic        eoc;

  int          n_vec = 0;
  int          n_miss = 0;
  int unsigned cyc = 0;
  logic [7:0]  exp_q[$];

  typedef struct {
    logic [7:0] addr;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs[12];
  logic [7:0] cal_exp[22];

  bmp180_responder #(
    .CYCLES_PER_US(1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus_start  (bus_start),
    .datareceive(datareceive),
    .received   (received),
    .datasend   (datasend),
    .sended     (sended),
    .temp_raw   (temp_raw),
    .press_raw  (press_raw),
    .eoc        (eoc)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_start();
    bus_start = 1'b1;
    tick();
    bus_start = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] b);
    datareceive = b;
    received    = 1'b1;
    tick();
    received    = 1'b0;
  endtask

  // Write transaction that only sets the pointer, then a repeated START.
  task automatic set_ptr(input logic [7:0] a);
    do_start();
    do_write(a);
    do_start();
  endtask

  // One master read: expectation queued, byte sampled once settled, then
  // the sended pulse; the scoreboard pops and compares.
  task automatic read_check(input string name, input logic [7:0] exp);
    logic [7:0] act;
    exp_q.push_back(exp);
    tick();
    tick();
    act    = datasend;
    sended = 1'b1;
    tick();
    sended = 1'b0;
    check(name, {24'h0, act}, {24'h0, exp_q.pop_front()});
  endtask

  // Poll every cycle until eoc rises (bounded), then check the low time.
  task automatic wait_eoc(input string name, input int unsigned t_fall, input int unsigned exp_len);
    int guard;
    guard = 0;
    while (eoc !== 1'b1 && guard < 40000) begin
      tick();
      guard++;
    end
    check(name, cyc - t_fall, exp_len);
  endtask

  // ---------------- test ----------------
  initial begin
    int unsigned t_fall;

    vecs[0]  = '{8'hD0, 8'h55};
    vecs[1]  = '{8'hF6, 8'h80};
    vecs[2]  = '{8'hF7, 8'h00};
    vecs[3]  = '{8'hF8, 8'h00};
    vecs[4]  = '{8'hAA, 8'h01};
    vecs[5]  = '{8'hAB, 8'h98};
    vecs[6]  = '{8'hB5, 8'h71};
    vecs[7]  = '{8'hBF, 8'h34};
    vecs[8]  = '{8'hC0, 8'h00};
    vecs[9]  = '{8'hF4, 8'h00};
    vecs[10] = '{8'hE0, 8'h00};
    vecs[11] = '{8'hFF, 8'h00};

    cal_exp = '{8'h01, 8'h98, 8'hFF, 8'hB8, 8'hC7, 8'hD1, 8'h7F, 8'hE5,
                8'h7F, 8'hF5, 8'h5A, 8'h71, 8'h18, 8'h2E, 8'h00, 8'h04,
                8'h80, 8'h00, 8'hDD, 8'hF9, 8'h0B, 8'h34};

    // Reset state
    tick();
    tick();
    check("reset_datasend", {24'h0, datasend}, 32'h00);
    check("reset_eoc", {31'h0, eoc}, 32'h1);
    reset = 1'b1;
    tick();
    tick();

    // Table: single-register reads
    for (int i = 0; i < 12; i++) begin
      set_ptr(vecs[i].addr);
      read_check($sformatf("vec%0d_rd_%0h", i, vecs[i].addr), vecs[i].exp);
    end

    // Calibration burst plus the first unmapped address after it
    set_ptr(8'hAA);
    for (int i = 0; i < 22; i++) begin
      read_check($sformatf("cal_burst[%0d]", i), cal_exp[i]);
    end
    read_check("cal_burst_C0", 8'h00);

    // Pointer wrap 0xFF -> 0x00
    set_ptr(8'hFF);
    read_check("wrap_FF", 8'h00);
    read_check("wrap_00", 8'h00);

    // Unknown command is stored but starts nothing
    do_start();
    do_write(8'hF4);
    do_write(8'h12);
    tick();
    check("bad_cmd_eoc", {31'h0, eoc}, 32'h1);
    set_ptr(8'hF4);
    read_check("bad_cmd_ctrl", 8'h12);

    // Temperature conversion; temp_raw changes mid-conversion so only the
    // value present at the end may appear in the result.
    temp_raw = 16'h1111;
    do_start();
    do_write(8'hF4);
    check("temp_eoc_before", {31'h0, eoc}, 32'h1);
    do_write(8'h2E);
    t_fall = cyc;
    check("temp_eoc_fall", {31'h0, eoc}, 32'h0);
    do_start();
    do_write(8'hF4);
    do_write(8'h34);                      // ignored: conversion running
    set_ptr(8'hF6);
    read_check("temp_hold_F6", 8'h80);
    set_ptr(8'hF4);
    read_check("temp_sco_busy", 8'h2E);
    temp_raw = 16'h6CFA;
    wait_eoc("temp_eoc_low_cycles", t_fall, 4500);
    set_ptr(8'hF4);
    read_check("temp_ctrl_done", 8'h0E);
    read_check("temp_F5", 8'h00);
    read_check("temp_F6", 8'h6C);
    read_check("temp_F7", 8'hFA);
    read_check("temp_F8", 8'h00);

    // received and sended together: only one pointer step
    do_start();
    do_write(8'hF5);
    datareceive = 8'h99;
    received    = 1'b1;
    sended      = 1'b1;
    tick();
    received    = 1'b0;
    sended      = 1'b0;
    read_check("rx_wins_over_tx", 8'h6C);

    // Pressure, oss=3
    press_raw = 19'h5D23C;
    do_start();
    do_write(8'hF4);
    do_write(8'hF4);
    t_fall = cyc;
    check("press3_eoc_fall", {31'h0, eoc}, 32'h0);
    wait_eoc("press3_eoc_low_cycles", t_fall, 25500);
    set_ptr(8'hF4);
    read_check("press3_ctrl", 8'hD4);
    read_check("press3_F5", 8'h00);
    read_check("press3_F6", 8'hBA);
    read_check("press3_F7", 8'h47);
    read_check("press3_F8", 8'h80);

    // Pressure, oss=0: shift by 8 truncates the top bits
    do_start();
    do_write(8'hF4);
    do_write(8'h34);
    t_fall = cyc;
    wait_eoc("press0_eoc_low_cycles", t_fall, 4500);
    set_ptr(8'hF6);
    read_check("press0_F6", 8'hD2);
    read_check("press0_F7", 8'h3C);
    read_check("press0_F8", 8'h00);

`ifdef BMP180_SOFT_RESET_EN
    // Soft reset mid-pressure conversion
    do_start();
    do_write(8'hF4);
    do_write(8'hB4);
    tick();
    tick();
    do_start();
    do_write(8'hE0);
    do_write(8'h12);                      // not the reset code
    tick();
    check("soft_other_eoc", {31'h0, eoc}, 32'h0);
    do_start();
    do_write(8'hE0);
    do_write(8'hB6);
    tick();
    check("soft_rst_eoc", {31'h0, eoc}, 32'h1);
    set_ptr(8'hF4);
    read_check("soft_rst_ctrl", 8'h00);
    read_check("soft_rst_F5", 8'h00);
    read_check("soft_rst_F6", 8'h80);
    read_check("soft_rst_F7", 8'h00);
    set_ptr(8'hE0);
    read_check("soft_rst_E0_reads0", 8'h00);
`endif

    // Async reset mid-read during a conversion
    do_start();
    do_write(8'hF4);
    do_write(8'h2E);
    set_ptr(8'hF4);
    tick();
    tick();
    check("arst_pre_datasend", {24'h0, datasend}, 32'h2E);
    #2;
    reset = 1'b0;
    #1;
    check("arst_datasend", {24'h0, datasend}, 32'h00);
    check("arst_eoc", {31'h0, eoc}, 32'h1);
    tick();
    reset = 1'b1;
    tick();
    set_ptr(8'hF4);
    read_check("arst_ctrl", 8'h00);
    set_ptr(8'hF6);
    read_check("arst_F6", 8'h80);
    tick();
    check("arst_eoc_stays", {31'h0, eoc}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
